// File: rtl/io_timer.sv
// Machine timer on the 8-bit IO bus: 64-bit mtime with prescaler, 64-bit mtimecmp, level interrupt.
// Latency: read data registered, valid the cycle after io_en; writes land at the end of the access cycle.
// Backpressure: none; every access completes in one cycle with no wait states.
module io_timer #(
    parameter logic [7:0] BASE = 8'h40
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic [7:0]  io_addr,
    input  logic        io_en,
    input  logic        io_we,
    input  logic [31:0] io_data_write,
    output logic [31:0] io_data_read,
    output logic        irq_mtimecmp
);

    localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
    localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] OFF_CTRL        = 3'd4;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        en_q, en_d;
    logic [7:0]  presc_q, presc_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;

    logic        sel;
    logic        wr;
    logic        rd;
    logic [2:0]  off;
    logic        tick;
    logic [31:0] rd_val;

    // Byte-lane bits of the address carry no information for word registers.
    logic        addr_unused;
    assign addr_unused = ^io_addr[1:0];

    assign sel = io_en && (io_addr[7:5] == BASE[7:5]);
    assign off = io_addr[4:2];
    assign wr  = sel && io_we;
    assign rd  = sel && !io_we;

    // A tick fires on the cycle the prescaler count reaches PRESC.
    assign tick = en_q && (pcnt_q == presc_q);

    // Read mux over the register map; holes in the window read as zero.
    always_comb begin
        rd_val = 32'h0;
        case (off)
            OFF_MTIME_LO:    rd_val = mtime_q[31:0];
            OFF_MTIME_HI:    rd_val = shadow_q;
            OFF_MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
            OFF_MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
            OFF_CTRL:        rd_val = {16'h0, presc_q, 7'h0, en_q};
            default:         rd_val = 32'h0;
        endcase
    end

    // Next-state for counter, prescaler, bus writes, read shadow and interrupt.
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
        presc_d    = presc_q;
        pcnt_d     = 8'h0;
        shadow_d   = shadow_q;
        rdata_d    = rdata_q;
        irq_d      = (mtime_q >= mtimecmp_q);

        // Prescaler keeps counting even when software rewrites mtime.
        if (en_q) begin
            pcnt_d = tick ? 8'h0 : pcnt_q + 8'd1;
        end

        if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        // A software write to one mtime half wins over that cycle's tick.
        if (wr) begin
            case (off)
                OFF_MTIME_LO:    mtime_d = {mtime_q[63:32], io_data_write};
                OFF_MTIME_HI:    mtime_d = {io_data_write, mtime_q[31:0]};
                OFF_MTIMECMP_LO: mtimecmp_d[31:0]  = io_data_write;
                OFF_MTIMECMP_HI: mtimecmp_d[63:32] = io_data_write;
                OFF_CTRL: begin
                    en_d    = io_data_write[0];
                    presc_d = io_data_write[15:8];
                    pcnt_d  = 8'h0;
                end
                default: ;
            endcase
        end

        // Reading LO snapshots HI so a LO/HI pair is coherent across a carry.
        if (rd) begin
            rdata_d = rd_val;
            if (off == OFF_MTIME_LO) begin
                shadow_d = mtime_q[63:32];
            end
        end else if (io_en && !io_we) begin
            rdata_d = 32'h0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            mtime_q    <= 64'h0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            en_q       <= 1'b1;
            presc_q    <= 8'h0;
            pcnt_q     <= 8'h0;
            shadow_q   <= 32'h0;
            rdata_q    <= 32'h0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            presc_q    <= presc_d;
            pcnt_q     <= pcnt_d;
            shadow_q   <= shadow_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign io_data_read = rdata_q;
    assign irq_mtimecmp = irq_q;

endmodule

// File: tb/tb_io_timer.sv
// Bench for io_timer: table of post-reset reads, directed multi-cycle sequences,
// then random bus traffic compared every cycle against a behavioural model.
module tb_io_timer;

    logic        clk = 1'b0;
    logic        resetb;
    logic [7:0]  io_addr;
    logic        io_en;
    logic        io_we;
    logic [31:0] io_data_write;
    logic [31:0] io_data_read;
    logic        irq_mtimecmp;

    int n_pass  = 0;
    int n_total = 0;

    io_timer #(.BASE(8'h40)) dut (
        .clk           (clk),
        .resetb        (resetb),
        .io_addr       (io_addr),
        .io_en         (io_en),
        .io_we         (io_we),
        .io_data_write (io_data_write),
        .io_data_read  (io_data_read),
        .irq_mtimecmp  (irq_mtimecmp)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] A_LO    = 8'h40;
    localparam logic [7:0] A_HI    = 8'h44;
    localparam logic [7:0] A_CMPLO = 8'h48;
    localparam logic [7:0] A_CMPHI = 8'h4C;
    localparam logic [7:0] A_CTRL  = 8'h50;

    // Behavioural model: time value, compare value, control fields,
    // cycles elapsed in the current prescale period, shadow, outputs.
    logic [63:0] m_time;
    logic [63:0] m_cmp;
    logic        m_en;
    logic [7:0]  m_presc;
    int          m_phase;
    logic [31:0] m_shadow;
    logic [31:0] m_rdata;
    logic        m_irq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] off);
        case (off)
            3'd0:    return m_time[31:0];
            3'd1:    return m_shadow;
            3'd2:    return m_cmp[31:0];
            3'd3:    return m_cmp[63:32];
            3'd4:    return {16'h0, m_presc, 7'h0, m_en};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_time   = 64'h0;
        m_cmp    = '1;
        m_en     = 1'b1;
        m_presc  = 8'h0;
        m_phase  = 0;
        m_shadow = 32'h0;
        m_rdata  = 32'h0;
        m_irq    = 1'b0;
    endtask

    // One clock edge of the model, all updates derived from pre-edge values.
    task automatic model_edge(input logic rb, input logic en, input logic we,
                              input logic [7:0] addr, input logic [31:0] wd);
        logic        hit;
        logic [2:0]  off;
        bit          period_done;
        logic [63:0] t_next;
        int          ph_next;
        if (!rb) begin
            model_reset();
            return;
        end
        hit = en && (addr[7:5] == 3'b010);
        off = addr[4:2];
        period_done = m_en && (m_phase == int'(m_presc));
        ph_next = !m_en ? 0 : (period_done ? 0 : m_phase + 1);
        t_next  = period_done ? m_time + 64'd1 : m_time;
        m_irq = (m_time >= m_cmp);
        if (en && !we) begin
            m_rdata = hit ? m_read(off) : 32'h0;
            if (hit && off == 3'd0) m_shadow = m_time[63:32];
        end
        if (hit && we) begin
            case (off)
                3'd0: t_next = {m_time[63:32], wd};
                3'd1: t_next = {wd, m_time[31:0]};
                3'd2: m_cmp[31:0]  = wd;
                3'd3: m_cmp[63:32] = wd;
                3'd4: begin
                    m_en    = wd[0];
                    m_presc = wd[15:8];
                    ph_next = 0;
                end
                default: ;
            endcase
        end
        m_time  = t_next;
        m_phase = ph_next;
    endtask

    // Drive one bus cycle, advance DUT and model, compare outputs just after the edge.
    task automatic step(input logic rb, input logic en, input logic we,
                        input logic [7:0] addr, input logic [31:0] wd);
        resetb = rb; io_en = en; io_we = we; io_addr = addr; io_data_write = wd;
        @(posedge clk);
        model_edge(rb, en, we, addr, wd);
        #1;
        check("model_rdata", io_data_read, m_rdata);
        check("model_irq", {31'h0, irq_mtimecmp}, {31'h0, m_irq});
        resetb = 1'b1; io_en = 1'b0; io_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [7:0] a);
        step(1'b1, 1'b1, 1'b0, a, 32'h0);
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[5];

    task automatic run_reset_table(input string tag);
        for (int i = 0; i < 5; i++) begin
            rd(tbl[i].addr);
            check({tag, "_", tbl[i].name}, io_data_read, tbl[i].exp);
        end
    endtask

    initial begin
        logic [31:0] a, b;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [2:0]  off;

        tbl[0] = '{A_LO,    32'h0000_0000, "mtime_lo"};
        tbl[1] = '{A_HI,    32'h0000_0000, "mtime_hi"};
        tbl[2] = '{A_CMPLO, 32'hFFFF_FFFF, "cmp_lo"};
        tbl[3] = '{A_CMPHI, 32'hFFFF_FFFF, "cmp_hi"};
        tbl[4] = '{A_CTRL,  32'h0000_0001, "ctrl"};

        model_reset();
        resetb = 1'b0; io_en = 1'b0; io_we = 1'b0; io_addr = 8'h0; io_data_write = 32'h0;
        step(1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
        check("reset_rdata", io_data_read, 32'h0);
        check("reset_irq", {31'h0, irq_mtimecmp}, 32'h0);

        // Reset values, first read right after reset release.
        run_reset_table("rst");
        check("rst_irq", {31'h0, irq_mtimecmp}, 32'h0);

        // Free run at PRESC=0: ten cycles apart reads differ by ten.
        idle(3);
        rd(A_LO); a = io_data_read;
        idle(9);
        rd(A_LO); b = io_data_read;
        check("freerun_diff", b - a, 32'd10);

        // PRESC=3: one increment per four cycles.
        wr(A_CTRL, 32'h0000_0301);
        rd(A_LO); a = io_data_read;
        idle(3);
        rd(A_LO); b = io_data_read;
        check("presc3_diff", b - a, 32'd1);
        rd(A_CTRL);
        check("presc3_ctrl", io_data_read, 32'h0000_0301);

        // EN=0 freezes the counter.
        wr(A_CTRL, 32'h0);
        rd(A_LO); a = io_data_read;
        idle(5);
        rd(A_LO); b = io_data_read;
        check("frozen_diff", b - a, 32'd0);

        // EN=1 resumes at one per cycle.
        wr(A_CTRL, 32'h1);
        rd(A_LO); a = io_data_read;
        idle(4);
        rd(A_LO); b = io_data_read;
        check("resume_diff", b - a, 32'd5);

        // Carry across the 32-bit boundary with shadowed high half.
        wr(A_HI, 32'h0);
        wr(A_LO, 32'hFFFF_FFFE);
        idle(1);
        rd(A_LO);
        check("wrap_lo_before", io_data_read, 32'hFFFF_FFFF);
        rd(A_HI);
        check("wrap_hi_shadow", io_data_read, 32'h0);
        rd(A_LO);
        check("wrap_lo_after", io_data_read, 32'h1);
        rd(A_HI);
        check("wrap_hi_after", io_data_read, 32'h1);

        // Interrupt timing around mtime reaching mtimecmp.
        wr(A_CTRL, 32'h0);
        wr(A_CMPHI, 32'h0);
        wr(A_CMPLO, 32'd100);
        wr(A_HI, 32'h0);
        wr(A_LO, 32'd90);
        wr(A_CTRL, 32'h1);
        idle(10);
        check("irq_not_yet", {31'h0, irq_mtimecmp}, 32'h0);
        idle(1);
        check("irq_rise", {31'h0, irq_mtimecmp}, 32'h1);
        wr(A_CMPHI, 32'h1);
        check("irq_hold_after_wr", {31'h0, irq_mtimecmp}, 32'h1);
        idle(1);
        check("irq_fall", {31'h0, irq_mtimecmp}, 32'h0);

        // Out-of-window accesses: zero read data, no register side effects.
        rd(A_CTRL);
        check("ctrl_before_oow", io_data_read, 32'h1);
        rd(8'h00);
        check("oow_read_zero", io_data_read, 32'h0);
        wr(8'h08, 32'h5);
        rd(A_CMPLO);
        check("oow_write_ignored", io_data_read, 32'd100);
        rd(8'h58);
        check("hole_read_zero", io_data_read, 32'h0);

        // Reset pulse mid-count.
        idle(3);
        step(1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
        check("midrst_rdata", io_data_read, 32'h0);
        run_reset_table("midrst");

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            off = 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 9) == 0) ? 8'($urandom) : {3'b010, off, 2'($urandom)};
            case (addr[4:2])
                3'd1, 3'd3: wd = 32'($urandom_range(0, 1));
                3'd4: wd = {$urandom} & 32'hFFFF_03FE | {31'h0, 1'($urandom_range(0, 3) != 0)};
                default: wd = 32'($urandom_range(0, 300));
            endcase
            if ($urandom_range(0, 199) == 0)
                step(1'b0, 1'($urandom), 1'($urandom), addr, wd);
            else
                step(1'b1, 1'($urandom_range(0, 2) == 0), 1'($urandom), addr, wd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
